// File: rtl/pp_accum_stage_pkg.sv
// Shared types, default widths and cost helpers for the partial-product accumulate stage.
package pp_accum_stage_pkg;

    localparam int PP_W_DEF  = 15;
    localparam int ACC_W_DEF = 20;
    localparam int CNT_W_DEF = 5;
    localparam int COST_W    = 51;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Per-bit weights of the ADD and MX primitives and of a magnitude-compare bit.
    localparam int ADD_COST_PER_BIT = 10;
    localparam int MX_COST_PER_BIT  = 4;
    localparam int CMP_COST_PER_BIT = 3;

    function automatic logic [COST_W-1:0] add_cost(input int w);
        return COST_W'(w * ADD_COST_PER_BIT);
    endfunction

    function automatic logic [COST_W-1:0] mx_cost(input int w);
        return COST_W'(w * MX_COST_PER_BIT);
    endfunction

    function automatic logic [COST_W-1:0] cmp_cost(input int w);
        return COST_W'(w * CMP_COST_PER_BIT);
    endfunction

endpackage

// File: rtl/pp_accum_stage_if.sv
// Term input and result output handshake bundle of the accumulate stage.
interface pp_accum_stage_if
    import pp_accum_stage_pkg::*;
#(
    parameter int PP_W  = PP_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             i_valid;
    logic [PP_W-1:0]  i_align_pp;
    logic             i_last;
    logic             o_ready;
    logic             o_valid;
    logic             i_out_ready;
    logic [ACC_W-1:0] o_sum;
    logic [CNT_W-1:0] o_terms;
    logic             o_cnt_ovf;
    logic             o_ovf;

    modport master (
        output i_valid, i_align_pp, i_last, i_out_ready,
        input  o_ready, o_valid, o_sum, o_terms, o_cnt_ovf, o_ovf
    );

    modport slave (
        input  i_valid, i_align_pp, i_last, i_out_ready,
        output o_ready, o_valid, o_sum, o_terms, o_cnt_ovf, o_ovf
    );
endinterface

// File: rtl/pp_accum_stage_add.sv
// Sign-extend + add datapath of the accumulator, saturating when PP_ACCUM_SAT_EN is defined.
module pp_acc_add
    import pp_accum_stage_pkg::*;
#(
    parameter int PP_W  = PP_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PP_W-1:0]   pp,
    input  logic              start,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic [COST_W-1:0] number
);
    logic [ACC_W-1:0] pp_ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] raw;

    // A fresh group adds onto zero, so its first term can never overflow.
    assign pp_ext = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    assign base   = start ? '0 : acc;
    assign raw    = base + pp_ext;

`ifdef PP_ACCUM_SAT_EN
    logic pos_ovf;
    logic neg_ovf;

    assign pos_ovf = ~base[ACC_W-1] & ~pp_ext[ACC_W-1] &  raw[ACC_W-1];
    assign neg_ovf =  base[ACC_W-1] &  pp_ext[ACC_W-1] & ~raw[ACC_W-1];
    assign sum     = pos_ovf ? {1'b0, {(ACC_W-1){1'b1}}} :
                     neg_ovf ? {1'b1, {(ACC_W-1){1'b0}}} : raw;
    assign ovf     = pos_ovf | neg_ovf;
    assign number  = add_cost(ACC_W) + mx_cost(ACC_W) + mx_cost(ACC_W) + mx_cost(ACC_W)
                   + cmp_cost(3);
`else
    assign sum    = raw;
    assign ovf    = 1'b0;
    assign number = add_cost(ACC_W) + mx_cost(ACC_W);
`endif

endmodule

// File: rtl/pp_accum_stage.sv
// Accumulates one dot-product group of aligned partial products and hands the sum downstream.
// Optional saturation is enabled with the PP_ACCUM_SAT_EN macro.
module pp_accum_stage
    import pp_accum_stage_pkg::*;
#(
    parameter int PP_W  = PP_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    pp_accum_stage_if.slave   bus,
    output logic [COST_W-1:0] number
);
    state_t           state;
    state_t           next_state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_ovf;
    logic             ovf;

    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] terms_q;
    logic             cnt_ovf_q;
    logic             ovf_q;

    logic             ready;
    logic             accept;
    logic             start;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_ovf_next;
    logic             ovf_next;

    pp_acc_add #(
        .PP_W  (PP_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc),
        .pp     (bus.i_align_pp),
        .start  (start),
        .sum    (add_sum),
        .ovf    (add_ovf),
        .number (number)
    );

    // NOTE: every combinational output is given a default first so no latch can be inferred.
    always_comb begin
        ready        = (state == ST_DONE) ? bus.i_out_ready : 1'b1;
        accept       = bus.i_valid & ready;
        start        = (state != ST_ACCUM);
        cnt_next     = CNT_W'(1);
        cnt_ovf_next = 1'b0;
        ovf_next     = add_ovf;
        next_state   = state;

        if (!start) begin
            cnt_next     = (&cnt) ? cnt : cnt + CNT_W'(1);
            cnt_ovf_next = cnt_ovf | (&cnt);
            ovf_next     = ovf | add_ovf;
        end

        case (state)
            ST_IDLE: begin
                if (accept) next_state = bus.i_last ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (accept && bus.i_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                // Consuming the result and opening the next group share a cycle.
                if (ready) begin
                    if (accept) next_state = bus.i_last ? ST_DONE : ST_ACCUM;
                    else        next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            cnt_ovf   <= 1'b0;
            ovf       <= 1'b0;
            sum_q     <= '0;
            terms_q   <= '0;
            cnt_ovf_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                acc     <= add_sum;
                cnt     <= cnt_next;
                cnt_ovf <= cnt_ovf_next;
                ovf     <= ovf_next;
            end
            // Result registers only move on the closing term, which holds them under backpressure.
            if (accept && bus.i_last) begin
                sum_q     <= add_sum;
                terms_q   <= cnt_next;
                cnt_ovf_q <= cnt_ovf_next;
                ovf_q     <= ovf_next;
            end
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_valid   = (state == ST_DONE);
    assign bus.o_sum     = sum_q;
    assign bus.o_terms   = terms_q;
    assign bus.o_cnt_ovf = cnt_ovf_q;
    assign bus.o_ovf     = ovf_q;

endmodule

// File: tb/tb_pp_accum_stage.sv
// Scoreboard bench for pp_accum_stage: a bench-side model queues each group result when its
// last term is accepted and a monitor compares it when the stage hands the result over.
module tb_pp_accum_stage;
    import pp_accum_stage_pkg::*;

    localparam int PP_W  = 15;
    localparam int ACC_W = 20;
    localparam int CNT_W = 5;
    localparam longint MAX_POS = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint MAX_NEG = -(64'sd1 <<< (ACC_W-1));
    localparam int     CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] terms;
        logic             cnt_ovf;
        logic             ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [COST_W-1:0] number;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_acc;
    int     m_cnt;
    bit     m_cnt_ovf;
    bit     m_ovf;
    bit     m_open;

    always #5 clk = ~clk;

    pp_accum_stage_if #(.PP_W(PP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    pp_accum_stage #(.PP_W(PP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .number  (number)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [PP_W-1:0] pp, input logic last);
        exp_t e;
        if (!m_open) begin
            m_acc     = 0;
            m_cnt     = 0;
            m_cnt_ovf = 0;
            m_ovf     = 0;
            m_open    = 1;
        end
        m_acc = m_acc + longint'($signed(pp));
`ifdef PP_ACCUM_SAT_EN
        if (m_acc > MAX_POS) begin
            m_acc = MAX_POS;
            m_ovf = 1;
        end else if (m_acc < MAX_NEG) begin
            m_acc = MAX_NEG;
            m_ovf = 1;
        end
`endif
        if (m_cnt == CNT_MAX) m_cnt_ovf = 1;
        else                  m_cnt++;
        if (last) begin
            e.sum     = ACC_W'(m_acc);
            e.terms   = CNT_W'(m_cnt);
            e.cnt_ovf = m_cnt_ovf;
            e.ovf     = m_ovf;
            sb.push_back(e);
            m_open = 0;
        end
    endtask

    // Drives one term and returns just after the edge that accepted it, with i_valid dropped.
    task automatic send(input logic [PP_W-1:0] pp, input logic last);
        bit done = 0;
        bus.i_valid    = 1'b1;
        bus.i_align_pp = pp;
        bus.i_last     = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) begin
                @(posedge clk);
                done = 1;
            end
        end
        if (done) model_accept(pp, last);
        else      check("send_timeout", 64'd0, 64'd1);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_group(input logic [PP_W-1:0] pp, input int n);
        for (int i = 0; i < n; i++) send(pp, (i == n - 1));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sum",     64'(bus.o_sum),     64'(e.sum));
                check("sb_terms",   64'(bus.o_terms),   64'(e.terms));
                check("sb_cnt_ovf", 64'(bus.o_cnt_ovf), 64'(e.cnt_ovf));
                check("sb_ovf",     64'(bus.o_ovf),     64'(e.ovf));
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_align_pp  = '0;
        bus.i_last      = 1'b0;
        bus.i_out_ready = 1'b1;
        m_open          = 0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid",   64'(bus.o_valid),   64'd0);
        check("rst_ready",   64'(bus.o_ready),   64'd1);
        check("rst_sum",     64'(bus.o_sum),     64'd0);
        check("rst_terms",   64'(bus.o_terms),   64'd0);
        check("rst_cnt_ovf", 64'(bus.o_cnt_ovf), 64'd0);
        check("rst_ovf",     64'(bus.o_ovf),     64'd0);
        @(posedge clk);
        #1;

        // Mixed-sign three-term group
        send(15'h0010, 1'b0);
        send(15'h7FF0, 1'b0);
        send(15'h0005, 1'b1);
        @(negedge clk);
        check("mix_valid", 64'(bus.o_valid), 64'd1);
        check("mix_sum",   64'(bus.o_sum),   64'd5);
        check("mix_terms", 64'(bus.o_terms), 64'd3);
        @(posedge clk);
        #1;

        // Backpressure: result held, stage not ready, junk term ignored
        send(15'h0100, 1'b1);
        bus.i_out_ready = 1'b0;
        bus.i_valid     = 1'b1;
        bus.i_align_pp  = 15'h7FFF;
        bus.i_last      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready", 64'(bus.o_ready), 64'd0);
            check("bp_valid", 64'(bus.o_valid), 64'd1);
            check("bp_sum",   64'(bus.o_sum),   64'h100);
            check("bp_terms", 64'(bus.o_terms), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.i_valid     = 1'b0;
        bus.i_out_ready = 1'b1;
        send(15'h0001, 1'b1);
        @(negedge clk);
        check("b2b_valid", 64'(bus.o_valid), 64'd1);
        check("b2b_sum",   64'(bus.o_sum),   64'd1);

        // Reset mid-group discards the partial sum
        @(posedge clk);
        #1;
        send(15'h0003, 1'b0);
        send(15'h0004, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_open = 0;
        @(negedge clk);
        check("midrst_valid", 64'(bus.o_valid), 64'd0);
        @(posedge clk);
        #1;
        send(15'h0002, 1'b1);
        @(negedge clk);
        check("midrst_sum",   64'(bus.o_sum),   64'd2);
        check("midrst_terms", 64'(bus.o_terms), 64'd1);
        @(posedge clk);
        #1;

        // Random groups, back to back
        for (int g = 0; g < 8; g++) begin
            int len;
            len = int'($urandom_range(1, 5));
            for (int t = 0; t < len; t++) send(PP_W'($urandom), (t == len - 1));
        end
        @(posedge clk);
        #1;

        // Positive overflow and term-count saturation
        send_group(15'h3FFF, 40);
        @(negedge clk);
`ifdef PP_ACCUM_SAT_EN
        check("povf_sum", 64'(bus.o_sum), 64'h7FFFF);
        check("povf_ovf", 64'(bus.o_ovf), 64'd1);
`else
        check("povf_sum", 64'(bus.o_sum), 64'h9FFD8);
        check("povf_ovf", 64'(bus.o_ovf), 64'd0);
`endif
        check("povf_cnt_ovf", 64'(bus.o_cnt_ovf), 64'd1);
        check("povf_terms",   64'(bus.o_terms),   64'd31);
        @(posedge clk);
        #1;

        // Negative overflow
        send_group(15'h4000, 40);
        @(negedge clk);
`ifdef PP_ACCUM_SAT_EN
        check("novf_sum", 64'(bus.o_sum), 64'h80000);
        check("novf_ovf", 64'(bus.o_ovf), 64'd1);
`else
        check("novf_sum", 64'(bus.o_sum), 64'h60000);
        check("novf_ovf", 64'(bus.o_ovf), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Exactly 2^CNT_W-1 terms: full count, no count overflow; flags cleared from prior group
        send_group(15'h0001, 31);
        @(negedge clk);
        check("full_terms",   64'(bus.o_terms),   64'd31);
        check("full_cnt_ovf", 64'(bus.o_cnt_ovf), 64'd0);
        check("full_ovf",     64'(bus.o_ovf),     64'd0);
        @(posedge clk);
        #1;

        // Most-negative single term
        send(15'h4000, 1'b1);
        @(negedge clk);
        check("mneg_sum",   64'(bus.o_sum),   64'hFC000);
        check("mneg_terms", 64'(bus.o_terms), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("end_valid",    64'(bus.o_valid), 64'd0);
        check("sb_drained",   64'(sb.size()),   64'd0);
        check("number_const", 64'(number == '0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pp_accum_stage.md
Name: pp_accum_stage

Overview:
- Downstream consumer of the partial-product align stage.
- Takes a stream of 15-bit two's-complement aligned partial products (sign bit at [14]) and accumulates one dot-product group into a sign-extended ACC_W-bit register.
- Hands the finished sum to the normalize/round stage over a valid/ready handshake.
- Reports a static hardware-cost count like every other MAC subsystem block.

Parameters:
- PP_W, 15: width of incoming aligned partial product (two's complement).
- ACC_W, 20: accumulator and result width; must be >= PP_W+1.
- CNT_W, 5: term-counter width; groups longer than 2^CNT_W-1 terms flag o_cnt_ovf.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: synchronous active-low reset.
- i_valid, input, 1: i_align_pp/i_last valid this cycle.
- i_align_pp, input, PP_W: aligned partial product, two's complement.
- i_last, input, 1: marks final term of the current group.
- o_ready, output, 1: stage can accept a term this cycle.
- o_valid, output, 1: o_sum holds a finished group result.
- i_out_ready, input, 1: downstream accepts o_sum.
- o_sum, output, ACC_W: accumulated group sum, two's complement.
- o_terms, output, CNT_W: number of terms in the reported group.
- o_cnt_ovf, output, 1: term count exceeded 2^CNT_W-1 in the reported group.
- o_ovf, output, 1: accumulator overflow in the reported group (see Optional Feature).
- number, output, 51: static cost figure, the sum of all sub-instance number outputs; constant.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State goes to IDLE; accumulator and counter go to 0.
  - o_valid=0, o_sum=0, o_terms=0, o_cnt_ovf=0, o_ovf=0.
  - Reset mid-group discards the partial sum. Reset while DONE drops the pending result.
- States:
  - IDLE: no group open. o_ready=1.
  - ACCUM: group open. o_ready=1.
  - DONE: o_valid=1. o_ready=i_out_ready.
- Accept: accept = i_valid & o_ready. Inputs are ignored when accept=0.
- Sign extension: i_align_pp is sign-extended from bit PP_W-1 to ACC_W bits before the add.
- IDLE + accept:
  - acc <= sext(pp); cnt <= 1.
  - Next state is DONE if i_last, else ACCUM.
- ACCUM + accept:
  - acc <= acc + sext(pp); cnt <= cnt+1.
  - cnt saturates at all-ones and sets the sticky cnt_ovf.
  - Next state is DONE if i_last.
- Entering DONE: o_sum/o_terms/o_cnt_ovf/o_ovf are registered from the final acc/cnt/flags. o_valid=1 in the cycle after the last term is accepted (latency 1).
- DONE: outputs are held stable while i_out_ready=0.
- DONE + i_out_ready:
  - Result is consumed. o_valid drops next cycle unless a new single-term group (i_last=1) is accepted in the same cycle.
  - If a term is accepted in that cycle, it starts a fresh group exactly as from IDLE (no bubble).
  - Otherwise the next state is IDLE.
- Single-term group (i_last on first term): result equals sext(pp).
- Sign cases: pp=15'h4000 (most negative) sign-extends to ACC_W'hFC000 at ACC_W=20. pp=0 is a legal term.
- Flags are cleared at the start of each group.
- The number output is independent of the clock and reset.

Optional Feature:
- Macro: PP_ACCUM_SAT_EN.
- Defined:
  - Signed add overflow clamps acc to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - ovf is set sticky for the group and reported in o_ovf.
  - Saturation adder and comparators are included in number.
- Undefined:
  - Accumulator wraps modulo 2^ACC_W.
  - o_ovf is tied 0.

Decomposition:
- Shared package: PP_W, ACC_W and CNT_W defaults, state encoding constants (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), and the cost-count width (51).
- Natural sub-module: pp_acc_add (ACC_W sign-extend + ADD + optional saturate mux), built from the codebase ADD/MX primitives with its own number output.

Test Plan:
- Reset/idle: hold i_rst_n=0 for 2 cycles, then release with i_valid=0.
  - Required: o_valid=0, o_ready=1, o_sum=0.
- Mixed-sign group: 3-term group 15'h0010, 15'h7FF0 (-16), 15'h0005 with i_last on the third, i_out_ready=1.
  - Required: one cycle later o_valid=1, o_sum=5, o_terms=3.
- Backpressure: i_out_ready=0 for 4 cycles in DONE.
  - Required: o_sum stable, o_ready=0, new inputs ignored.
  - Then i_out_ready=1 with a new single-term 15'h0001, i_last → next cycle o_sum=1, o_valid stays 1.
- Reset mid-group: feed 2 terms, assert i_rst_n=0 for 1 cycle, then send a single-term group 15'h0002 with i_last.
  - Required: o_sum=2, o_terms=1.
- Overflow: 40 terms of 15'h3FFF (ACC_W=20, CNT_W=5).
  - With PP_ACCUM_SAT_EN: o_sum=20'h7FFFF, o_ovf=1, o_cnt_ovf=1.
  - Without PP_ACCUM_SAT_EN: o_sum=(40*16383) mod 2^20 = 20'h9FFD8, o_ovf=0.
- Most-negative term: single term 15'h4000 with i_last.
  - Required: o_sum=20'hFC000, o_terms=1.
